// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 register window.
// Feeds the pipelined 3x3 MAC element of the Conv3X3 datapath.
module conv3x3_window_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMG_WIDTH  = 224,
  parameter int unsigned IMG_HEIGHT = 224
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] o1,
  output logic [DATA_WIDTH-1:0] o2,
  output logic [DATA_WIDTH-1:0] o3,
  output logic [DATA_WIDTH-1:0] o4,
  output logic [DATA_WIDTH-1:0] o5,
  output logic [DATA_WIDTH-1:0] o6,
  output logic [DATA_WIDTH-1:0] o7,
  output logic [DATA_WIDTH-1:0] o8,
  output logic [DATA_WIDTH-1:0] o9,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] lb_a_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb_b_q [IMG_WIDTH];
  logic                  accept;

  // Reset takes priority over an incoming pixel.
  assign accept = valid_in & ~rst;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = lb_b_q[col_q];
      win_d[5] = lb_a_q[col_q];
      win_d[8] = i_data;
      // Rows 0-1 of a frame hold stale line-buffer data, cols 0-1 wrap rows.
      valid_out_d  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
      frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffers carry no reset; stale contents are masked by the row gate.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_b_q[col_q] <= lb_a_q[col_q];
      lb_a_q[col_q] <= i_data;
    end
  end

  assign o1         = win_q[0];
  assign o2         = win_q[1];
  assign o3         = win_q[2];
  assign o4         = win_q[3];
  assign o5         = win_q[4];
  assign o6         = win_q[5];
  assign o7         = win_q[6];
  assign o8         = win_q[7];
  assign o9         = win_q[8];
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule
